// File: rtl/posicionador_de_navios.sv
// ============================================================================
// Module   : posicionador_de_navios
// Brief    : Battleship ship-placement stage; validates and commits ships into
//            a 5x7 map that the attack phase reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module posicionador_de_navios #(
    parameter int TAM_NAVIO0 = 3,
    parameter int TAM_NAVIO1 = 2,
    parameter int TAM_NAVIO2 = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       confirmar,
    input  logic [2:0] coordColuna,
    input  logic [2:0] coordLinha,
    input  logic       orientacao,
    output logic [6:0] mapa0,
    output logic [6:0] mapa1,
    output logic [6:0] mapa2,
    output logic [6:0] mapa3,
    output logic [6:0] mapa4,
    output logic [6:0] previa0,
    output logic [6:0] previa1,
    output logic [6:0] previa2,
    output logic [6:0] previa3,
    output logic [6:0] previa4,
    output logic [1:0] navio_atual,
    output logic       LED_R,
    output logic       LED_G,
    output logic       concluido
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_POSICIONA = 2'd1,
        S_VALIDA    = 2'd2,
        S_CONCLUIDO = 2'd3
    } estado_t;

    estado_t         r_estado, w_prox_estado;
    logic            r_conf_q;
    logic [2:0]      r_col, r_lin;
    logic            r_ori;
    logic [4:0][6:0] r_mapa;
    logic [1:0]      r_navio;
    logic            r_led_r, r_led_g;

    logic            w_evento;
    logic [3:0]      w_tam;
    logic [4:0][6:0] w_masc_lat, w_masc_prev;
    logic            w_dentro, w_sem_sobrep, w_valido;

    function automatic logic [3:0] f_tam(input logic [1:0] navio);
        case (navio)
            2'd0:    f_tam = 4'(TAM_NAVIO0);
            2'd1:    f_tam = 4'(TAM_NAVIO1);
            default: f_tam = 4'(TAM_NAVIO2);
        endcase
    endfunction

    // Cells outside the 5x7 board simply fall off, giving the clipped mask.
    function automatic logic [4:0][6:0] f_mascara(input logic [2:0] col,
                                                  input logic [2:0] lin,
                                                  input logic       ori,
                                                  input logic [3:0] tam);
        logic [4:0][6:0] m;
        logic [15:0]     linhas;
        logic [7:0]      uma_linha;
        logic [3:0]      fim_col;
        m         = '0;
        linhas    = ((16'h1 << tam) - 16'h1) << lin;
        uma_linha = 8'h1 << lin;
        fim_col   = {1'b0, col} + tam - 4'd1;
        for (int x = 0; x < 5; x++) begin
            if (ori) begin
                if (col == 3'(x))
                    m[x] = linhas[6:0];
            end else if (({1'b0, col} <= 4'(x)) && (4'(x) <= fim_col)) begin
                m[x] = uma_linha[6:0];
            end
        end
        return m;
    endfunction

    assign w_evento    = confirmar & ~r_conf_q;
    assign w_tam       = f_tam(r_navio);
    assign w_masc_lat  = f_mascara(r_col, r_lin, r_ori, w_tam);
    assign w_masc_prev = f_mascara(coordColuna, coordLinha, orientacao, w_tam);

    assign w_dentro = (r_col <= 3'd4) && (r_lin <= 3'd6) &&
                      (r_ori ? (({1'b0, r_lin} + w_tam - 4'd1) <= 4'd6)
                             : (({1'b0, r_col} + w_tam - 4'd1) <= 4'd4));
    assign w_sem_sobrep = ((w_masc_lat & r_mapa) == '0);
    assign w_valido     = w_dentro && w_sem_sobrep && (r_navio <= 2'd2);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_estado <= S_IDLE;
        else        r_estado <= w_prox_estado;
    end

    always_comb begin
        w_prox_estado = r_estado;
        if (!enable) begin
            w_prox_estado = S_IDLE;
        end else begin
            case (r_estado)
                S_IDLE:      w_prox_estado = S_POSICIONA;
                S_POSICIONA: if (w_evento) w_prox_estado = S_VALIDA;
                S_VALIDA:    w_prox_estado = (w_valido && (r_navio == 2'd2))
                                             ? S_CONCLUIDO : S_POSICIONA;
                S_CONCLUIDO: w_prox_estado = S_CONCLUIDO;
                default:     w_prox_estado = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_conf_q <= 1'b0;
            r_col    <= '0;
            r_lin    <= '0;
            r_ori    <= 1'b0;
            r_mapa   <= '0;
            r_navio  <= '0;
            r_led_r  <= 1'b0;
            r_led_g  <= 1'b0;
        end else begin
            r_conf_q <= confirmar;
            if (!enable) begin
                r_mapa  <= '0;
                r_navio <= '0;
                r_led_r <= 1'b0;
                r_led_g <= 1'b0;
            end else begin
                if ((r_estado == S_POSICIONA) && w_evento) begin
                    r_col <= coordColuna;
                    r_lin <= coordLinha;
                    r_ori <= orientacao;
                end
                if (r_estado == S_VALIDA) begin
                    if (w_valido) begin
                        r_mapa  <= r_mapa | w_masc_lat;
                        r_navio <= r_navio + 2'd1;
                        r_led_g <= 1'b1;
                        r_led_r <= 1'b0;
                    end else begin
                        r_led_r <= 1'b1;
                        r_led_g <= 1'b0;
                    end
                end
            end
        end
    end

    assign mapa0 = r_mapa[0];
    assign mapa1 = r_mapa[1];
    assign mapa2 = r_mapa[2];
    assign mapa3 = r_mapa[3];
    assign mapa4 = r_mapa[4];

    always_comb begin
        {previa4, previa3, previa2, previa1, previa0} = r_mapa;
        if (r_estado == S_POSICIONA)
            {previa4, previa3, previa2, previa1, previa0} = r_mapa | w_masc_prev;
    end

    assign navio_atual = r_navio;
    assign LED_R       = r_led_r;
    assign LED_G       = r_led_g;
    assign concluido   = (r_estado == S_CONCLUIDO);

endmodule

`default_nettype wire

// File: tb/tb_posicionador_de_navios.sv
// ============================================================================
// Module   : tb_posicionador_de_navios
// Brief    : Directed self-checking bench for the ship-placement stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_posicionador_de_navios;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       confirmar = 1'b0;
    logic [2:0] coordColuna = '0;
    logic [2:0] coordLinha = '0;
    logic       orientacao = 1'b0;
    logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
    logic [6:0] previa0, previa1, previa2, previa3, previa4;
    logic [1:0] navio_atual;
    logic       LED_R, LED_G, concluido;

    int n_checks = 0;
    int n_errors = 0;

    posicionador_de_navios dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .confirmar   (confirmar),
        .coordColuna (coordColuna),
        .coordLinha  (coordLinha),
        .orientacao  (orientacao),
        .mapa0       (mapa0),
        .mapa1       (mapa1),
        .mapa2       (mapa2),
        .mapa3       (mapa3),
        .mapa4       (mapa4),
        .previa0     (previa0),
        .previa1     (previa1),
        .previa2     (previa2),
        .previa3     (previa3),
        .previa4     (previa4),
        .navio_atual (navio_atual),
        .LED_R       (LED_R),
        .LED_G       (LED_G),
        .concluido   (concluido)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One press: event sampled at edge k, inputs scrambled, result visible after edge k+1.
    task automatic press(input logic [2:0] c, input logic [2:0] l, input logic o);
        coordColuna = c;
        coordLinha  = l;
        orientacao  = o;
        confirmar   = 1'b1;
        @(posedge clock); #1;
        confirmar   = 1'b0;
        coordColuna = 3'd7;
        coordLinha  = 3'd7;
        @(posedge clock); #1;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_mapa", {mapa4, mapa3, mapa2, mapa1, mapa0}, 35'd0);
        chk("rst_navio", navio_atual, 2'd0);
        chk("rst_leds", {LED_R, LED_G, concluido}, 3'b000);
        reset  = 1'b1;
        enable = 1'b1;
        @(posedge clock); #1;

        // ship0 horizontal at (0,0), with latency check
        coordColuna = 3'd0; coordLinha = 3'd0; orientacao = 1'b0; confirmar = 1'b1;
        @(posedge clock); #1;
        chk("lat_mapa0", mapa0, 7'd0);
        confirmar = 1'b0; coordColuna = 3'd4;
        @(posedge clock); #1;
        chk("s0_mapa", {mapa4, mapa3, mapa2, mapa1, mapa0},
            {7'b0, 7'b0, 7'b0000001, 7'b0000001, 7'b0000001});
        chk("s0_leds", {LED_R, LED_G}, 2'b01);
        chk("s0_navio", navio_atual, 2'd1);

        // ship1 vertical out of bounds, then legal
        press(3'd4, 3'd6, 1'b1);
        chk("s1_oob_leds", {LED_R, LED_G}, 2'b10);
        chk("s1_oob_mapa4", mapa4, 7'd0);
        chk("s1_oob_navio", navio_atual, 2'd1);
        press(3'd4, 3'd5, 1'b1);
        chk("s1_mapa4", mapa4, 7'b1100000);
        chk("s1_leds", {LED_R, LED_G}, 2'b01);
        chk("s1_navio", navio_atual, 2'd2);

        // ship2 overlap, then legal, then ignored press
        press(3'd1, 3'd0, 1'b0);
        chk("s2_ovl_leds", {LED_R, LED_G}, 2'b10);
        chk("s2_ovl_mapa1", mapa1, 7'b0000001);
        press(3'd2, 3'd3, 1'b0);
        chk("s2_mapa2", mapa2, 7'b0001001);
        chk("s2_done", {concluido, navio_atual}, 3'b111);
        chk("s2_leds", {LED_R, LED_G}, 2'b01);
        press(3'd3, 3'd3, 1'b0);
        chk("done_mapa3", mapa3, 7'd0);
        chk("done_hold", {concluido, navio_atual, LED_R, LED_G}, 5'b11101);

        // clear by enable, then held button
        enable = 1'b0;
        @(posedge clock); #1;
        chk("clr_all", {mapa4, mapa3, mapa2, mapa1, mapa0, navio_atual, LED_R, LED_G, concluido},
            40'd0);
        enable = 1'b1;
        @(posedge clock); #1;
        coordColuna = 3'd1; coordLinha = 3'd1; orientacao = 1'b0; confirmar = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        confirmar = 1'b0;
        @(posedge clock); #1;
        chk("held_navio", navio_atual, 2'd1);
        chk("held_mapa", {mapa4, mapa3, mapa2, mapa1, mapa0},
            {7'b0, 7'b0000010, 7'b0000010, 7'b0000010, 7'b0});
        press(3'd1, 3'd1, 1'b0);
        chk("repress_leds", {LED_R, LED_G}, 2'b10);
        chk("repress_navio", navio_atual, 2'd1);

        // preview of ship1 (length 2)
        coordColuna = 3'd3; coordLinha = 3'd0; orientacao = 1'b0;
        #1;
        chk("prev_h", {previa4, previa3, previa2, previa1, previa0},
            {7'b0000001, 7'b0000011, 7'b0000010, 7'b0000010, 7'b0});
        coordColuna = 3'd4; coordLinha = 3'd6; orientacao = 1'b1;
        #1;
        chk("prev_clip_v", previa4, 7'b1000000);

        // out-of-board column with ship0
        enable = 1'b0;
        @(posedge clock); #1;
        enable = 1'b1;
        @(posedge clock); #1;
        coordColuna = 3'd5; coordLinha = 3'd0; orientacao = 1'b0;
        #1;
        chk("prev_col5", {previa4, previa3, previa2, previa1, previa0}, 35'd0);
        press(3'd5, 3'd0, 1'b0);
        chk("col5_leds", {LED_R, LED_G}, 2'b10);
        chk("col5_navio", navio_atual, 2'd0);

        // enable dropped while in VALIDA discards the placement
        coordColuna = 3'd0; coordLinha = 3'd0; orientacao = 1'b0; confirmar = 1'b1;
        @(posedge clock); #1;
        enable = 1'b0; confirmar = 1'b0;
        @(posedge clock); #1;
        chk("drop_mapa0", mapa0, 7'd0);
        chk("drop_state", {navio_atual, LED_R, LED_G, concluido}, 5'd0);

        // asynchronous reset mid-cycle
        enable = 1'b1;
        @(posedge clock); #1;
        press(3'd0, 3'd0, 1'b0);
        chk("pre_areset_mapa0", mapa0, 7'b0000001);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_mapa", {mapa4, mapa3, mapa2, mapa1, mapa0}, 35'd0);
        chk("areset_state", {navio_atual, LED_R, LED_G, concluido}, 5'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        n_errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/posicionador_de_navios.md
Name: posicionador_de_navios

Overview:
Ship-placement stage of the battleship game, and the writer of the map that the attack manager reads. The player selects a coordinate, an orientation and confirms, once per ship. Each placement is checked for board bounds and overlap, then committed into mapa0..mapa4 (5 columns × 7 rows). After the last ship is placed, the block raises concluido and holds the finished map for the attack phase.

Parameters:
TAM_NAVIO0, 3, length in cells of ship 0 (placed first); legal range 1..5
TAM_NAVIO1, 2, length of ship 1; legal range 1..5
TAM_NAVIO2, 1, length of ship 2 (placed last); legal range 1..5

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; clears all state
enable  input  1  placement phase active; low = synchronous clear to IDLE
confirmar  input  1  level confirm button; only its rising edge (sampled on clock) is an event
coordColuna  input  3  start column 0..4 (5..7 out of bounds)
coordLinha  input  3  start row 0..6 (7 out of bounds)
orientacao  input  1  0 = horizontal (increasing column), 1 = vertical (increasing row)
mapa0..mapa4  output  7 each  committed map; mapaC[r] = cell (column C, row r)
previa0..previa4  output  7 each  mapa OR current candidate mask (clipped to board); for LED matrix preview
navio_atual  output  2  index of ship being placed (0..2; 3 when done)
LED_R  output  1  last confirm rejected
LED_G  output  1  last confirm accepted
concluido  output  1  all ships placed

Behaviour:
- Reset (reset=0, asynchronous): mapa*=0, navio_atual=0, LED_R=LED_G=0, concluido=0, state=IDLE, confirm edge register=0.
- Edge detect: conf_q is registered every clock. evento = confirmar & ~conf_q. A held button produces exactly one event.
- States:
  - IDLE: wait for enable=1. Then go to POSICIONA next edge.
  - POSICIONA: on evento, latch coordColuna, coordLinha and orientacao, then go to VALIDA.
  - VALIDA: single cycle. On this edge, if the latched candidate is valid: mapa |= mask, navio_atual+1, LED_G=1, LED_R=0. If not valid: map unchanged, LED_R=1, LED_G=0. Next state is CONCLUIDO if the committed ship was ship 2, else POSICIONA.
  - CONCLUIDO: concluido=1, maps frozen. evento is ignored.
- Latency: evento is seen at edge k. The map, LEDs and navio_atual update at edge k+1. Input changes after edge k do not affect that placement.
- Candidate mask for ship length S at (c,r):
  - Horizontal: cells (c..c+S-1, r).
  - Vertical: cells (c, r..r+S-1).
  - Compute endpoint arithmetic at 4 bits; no wrap-around.
- Validity requires all three of:
  - in bounds: c≤4 and r≤6 and (horizontal: c+S-1≤4; vertical: r+S-1≤6);
  - no overlap: (mask & mapa) == 0 in every column;
  - navio_atual ≤ 2.
- previa*: combinational. Equals mapa OR (current-input mask clipped to board) while in POSICIONA; equals mapa otherwise.
- LED_R and LED_G are never both 1. Each holds its value until the next VALIDA or a clear.
- enable=0 in any state: on the next edge go to IDLE and clear mapa, navio_atual, LEDs and concluido. This includes a placement in VALIDA, which is discarded.
- evento arriving while in VALIDA is ignored; it is not queued.
- Illegal state encodings return to IDLE.

Test Plan:
- Reset, enable=1, confirm at col0 row0 horizontal → mapa0=mapa1=mapa2=7'b0000001, others 0; LED_G=1; navio_atual=1; update 1 cycle after the edge that samples the press.
- Ship1 vertical at col4 row6 → LED_R=1, LED_G=0, map unchanged, navio_atual=1. Then vertical at col4 row5 → mapa4=7'b1100000, LED_G=1, navio_atual=2.
- Ship2 at col1 row0 (overlaps ship0) → LED_R=1, no change. Then col2 row3 → mapa2=7'b0001001, concluido=1, navio_atual=3. A further press changes nothing.
- confirmar held high for 6 cycles with a valid ship0 → exactly one commit, navio_atual=1. Releasing and re-pressing with the same coordinates → overlap → LED_R=1.
- coordColuna=5 horizontal, ship0 → LED_R=1. previa* shows mapa only, with no clipped cells from column 5+.
- enable dropped during VALIDA → next edge: mapa*=0, navio_atual=0, LEDs 0, state IDLE. Asserting reset=0 mid-cycle clears all outputs immediately, without waiting for a clock edge.
